spi_adc_responder: RTL and testbench
====================================

// Module: spi_adc_responder
// PURPOSE
//  SPI slave that models the 16-bit-command ADC chip driven by our spi master; other end of that link.
//  Decodes CONVERT/CALIBRATE/CLEAR/WRITE/READ frames and returns pipelined 16-bit responses on miso.
//  Used as the bench/loopback chip model and on a second FPGA to stand in for the ADC.
// PARAMETERS
//  CAL_FRAMES   9      frames swallowed after CALIBRATE
//  CNT_W        10     width of synthetic conversion counter
// PORTS
//  clk         in   1   system clock; must be >= 8x sclk
//  rst         in   1   reset; asynchronous, active-high
//  sclk        in   1   SPI clock, CPOL=0/CPHA=0, async to clk
//  cs          in   1   chip select, active-low, async to clk
//  mosi        in   1   serial command in, MSB first
//  miso        out  1   serial response out, MSB first
//  reg3_q      out  8   current contents of register 3 (LED/debug)
//  frame_done  out  1   one-clk pulse: valid 16-bit frame executed
//  frame_err   out  1   one-clk pulse: frame with bit count != 16 discarded
//  cmd_q       out  16  last executed command word
// BEHAVIOUR
//  - sclk, cs, mosi: 2-FF synchronizers; edges detected on synced sclk/cs.
//  - Reset: miso=0, reg3_q=0, frame_done=0, frame_err=0, cmd_q=0, RW regs=0, conv_cnt=0,
//    cal_left=0, response pipeline=16'h0000, armed=0.
//  - armed set when synced cs high; a frame already in progress at reset release is ignored.
//  - cs fall (armed): bit_cnt<=0; tx_sr<=resp_out; miso=tx_sr[15] while cs low, 0 while cs high.
//  - sclk rise: rx_sr<={rx_sr[14:0],mosi}; bit_cnt++ saturating at 17. sclk fall: tx_sr<<=1.
//  - cs rise: bit_cnt==16 -> execute rx_sr, cmd_q<=rx_sr, frame_done pulse, advance pipeline;
//    else frame_err pulse, no state change, pipeline not advanced.
//  - Decode (cmd[15:14]):
//    00 CONVERT ch=cmd[13:8]: resp {ch, conv_cnt}; conv_cnt++ wrapping 1023->0.
//    10 WRITE reg=cmd[13:8]: regs 0..17 store cmd[7:0], others ignore; resp {8'hFF, cmd[7:0]}.
//    11 READ reg: resp {8'h00, value}; regs 0..17 RW; 40..44 ROM 49,4E,54,41,4E ("INTAN");
//       63 = 8'h01 chip id; all other addresses read 8'h00.
//    16'h5500 CALIBRATE: resp 16'h0000; cal_left<=CAL_FRAMES.
//    16'h6A00 CLEAR: conv_cnt<=0; resp 16'h0000.
//    other 01xxxxxx: illegal, resp 16'hFFFF, no state change.
//  - cal_left!=0: valid frame not decoded, resp 16'h0000, cal_left--; err frames do not count.
//  - Latency: response of frame n is shifted out in frame n+2 (see CONFIGURATION).
//  - Simultaneous cs rise and sclk edge in the same clk: cs edge wins, sclk edge dropped.
// CONFIGURATION
//  SPI_RESP_LATENCY2_EN defined: two-stage response pipeline, frame n answer appears in frame n+2
//    (chip-accurate); first two frames after reset return 16'h0000.
//  Not defined: single stage, answer in frame n+1; first frame after reset returns 16'h0000.
// STRUCTURE
//  Package spi_adc_pkg: opcode constants (CMD_WRITE/READ 2-bit, CALIBRATE 16'h5500, CLEAR 16'h6A00),
//    register addresses, ROM values, response constants RET_WRITE 8'hFF / RET_READ 8'h00.
//  Sub-module spi_adc_regfile: 18x8 RW array + ROM decode, sync write, comb read.
//  Top holds synchronizers, shift registers, bit counter, decoder, pipeline, cal counter.
// TESTING
//  1 WRITE 16'h8301, then READ 16'hC300, CONVERT x2 -> frame3 miso 16'hFF01, frame4 16'h0001, reg3_q=8'h01.
//  2 READ 16'hE800 (reg 40) then 4 dummies -> 16'h0049 in frame+2; reg 44 -> 16'h004E; reg 20 -> 16'h0000.
//  3 CONVERT ch5 x1025 -> responses {6'd5,10'd0..1023} then {6'd5,10'd0} wrap; CLEAR -> next CONVERT gives cnt 0.
//  4 CALIBRATE then 9 WRITEs to reg3 -> reg3_q unchanged, 9 responses 16'h0000; 10th WRITE takes effect.
//  5 15-bit and 17-bit frames -> frame_err pulse each, frame_done 0, reg/pipeline unchanged.
//  6 rst pulsed mid-frame with cs low -> outputs at reset values, that frame ignored, next frame normal;
//    run 1-5 with and without SPI_RESP_LATENCY2_EN checking n+2 vs n+1 alignment.

Source files
------------

// File: rtl/spi_adc_pkg.sv
// Shared opcodes, register map and response constants for the ADC chip model.
package spi_adc_pkg;

  localparam logic [1:0]  CMD_CONVERT   = 2'b00;
  localparam logic [1:0]  CMD_ILLEGAL   = 2'b01;
  localparam logic [1:0]  CMD_WRITE     = 2'b10;
  localparam logic [1:0]  CMD_READ      = 2'b11;
  localparam logic [15:0] CMD_CALIBRATE = 16'h5500;
  localparam logic [15:0] CMD_CLEAR     = 16'h6A00;

  localparam logic [5:0]  RW_REG_LIMIT  = 6'd18;
  localparam int          NUM_RW_REGS   = 18;
  localparam logic [5:0]  ADDR_CHIP_ID  = 6'd63;
  localparam logic [7:0]  CHIP_ID       = 8'h01;

  localparam logic [7:0]  RET_WRITE     = 8'hFF;
  localparam logic [7:0]  RET_READ      = 8'h00;
  localparam logic [15:0] RESP_ZERO     = 16'h0000;
  localparam logic [15:0] RESP_ILLEGAL  = 16'hFFFF;

  localparam logic [4:0]  BIT_CNT_FULL  = 5'd16;
  localparam logic [4:0]  BIT_CNT_MAX   = 5'd17;

  typedef enum logic [1:0] {
    ST_DISARMED,
    ST_IDLE,
    ST_FRAME
  } frameState_t;

  // Read-only "INTAN" identification string at addresses 40..44.
  function automatic logic [7:0] romValue(input logic [5:0] addr);
    case (addr)
      6'd40:   romValue = 8'h49;
      6'd41:   romValue = 8'h4E;
      6'd42:   romValue = 8'h54;
      6'd43:   romValue = 8'h41;
      6'd44:   romValue = 8'h4E;
      default: romValue = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/spi_adc_regfile.sv
// Register file of the ADC chip model: 18 RW bytes, ROM id string and chip id.
module spi_adc_regfile (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_wrEn,
  input  logic [5:0] i_addr,
  input  logic [7:0] i_wrData,
  output logic [7:0] o_rdData,
  output logic [7:0] o_reg3Q
);
  import spi_adc_pkg::*;

  logic [7:0] r_regs [NUM_RW_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_RW_REGS; i++) r_regs[i] <= '0;
    end else if (i_wrEn && (i_addr < RW_REG_LIMIT)) begin
      r_regs[i_addr[4:0]] <= i_wrData;
    end
  end

  always_comb begin
    o_rdData = 8'h00;
    if (i_addr < RW_REG_LIMIT)       o_rdData = r_regs[i_addr[4:0]];
    else if (i_addr == ADDR_CHIP_ID) o_rdData = CHIP_ID;
    else                             o_rdData = romValue(i_addr);
  end

  assign o_reg3Q = r_regs[3];

endmodule

// File: rtl/spi_adc_responder.sv
// SPI mode-0 slave modelling the 16-bit-command ADC chip (loopback / stand-in for the real part).
// Define SPI_RESP_LATENCY2_EN for the chip-accurate two-frame response latency; default is one frame.
module spi_adc_responder #(
  parameter int CAL_FRAMES = 9,
  parameter int CNT_W      = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_sclk,
  input  logic        i_cs,
  input  logic        i_mosi,
  output logic        o_miso,
  output logic [7:0]  o_reg3Q,
  output logic        o_frameDone,
  output logic        o_frameErr,
  output logic [15:0] o_cmdQ
);
  import spi_adc_pkg::*;

  localparam int CAL_W = $clog2(CAL_FRAMES + 1);

  logic              r_sclkMeta, r_sclkSync, r_sclkDly;
  logic              r_csMeta, r_csSync;
  logic              r_mosiMeta, r_mosiSync;
  frameState_t       r_state;
  logic [4:0]        r_bitCnt;
  logic [15:0]       r_rxSr, r_txSr, r_cmdQ;
  logic              r_frameDone, r_frameErr;
  logic [CNT_W-1:0]  r_convCnt;
  logic [CAL_W-1:0]  r_calLeft;
  logic [15:0]       r_pipe0;
  logic              w_sclkRise, w_sclkFall, w_exec;
  logic [15:0]       w_resp, w_respOut;
  logic              w_wrCmd, w_convInc, w_convClr, w_calStart;
  logic [7:0]        w_rdData;

  // Synchronizers reset to 0 so a frame already running at reset release never looks like cs high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclkMeta <= 1'b0; r_sclkSync <= 1'b0; r_sclkDly <= 1'b0;
      r_csMeta   <= 1'b0; r_csSync   <= 1'b0;
      r_mosiMeta <= 1'b0; r_mosiSync <= 1'b0;
    end else begin
      r_sclkMeta <= i_sclk; r_sclkSync <= r_sclkMeta; r_sclkDly <= r_sclkSync;
      r_csMeta   <= i_cs;   r_csSync   <= r_csMeta;
      r_mosiMeta <= i_mosi; r_mosiSync <= r_mosiMeta;
    end
  end

  assign w_sclkRise = r_sclkSync & ~r_sclkDly;
  assign w_sclkFall = ~r_sclkSync & r_sclkDly;
  assign w_exec     = (r_state == ST_FRAME) && r_csSync && (r_bitCnt == BIT_CNT_FULL);

  // Frame FSM; cs rising is checked first so a coincident sclk edge is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_DISARMED;
      r_bitCnt    <= '0;
      r_rxSr      <= '0;
      r_txSr      <= '0;
      r_cmdQ      <= '0;
      r_frameDone <= 1'b0;
      r_frameErr  <= 1'b0;
    end else begin
      r_frameDone <= 1'b0;
      r_frameErr  <= 1'b0;
      case (r_state)
        ST_DISARMED: if (r_csSync) r_state <= ST_IDLE;
        ST_IDLE: begin
          if (!r_csSync) begin
            r_state  <= ST_FRAME;
            r_bitCnt <= '0;
            r_txSr   <= w_respOut;
          end
        end
        ST_FRAME: begin
          if (r_csSync) begin
            r_state <= ST_IDLE;
            if (r_bitCnt == BIT_CNT_FULL) begin
              r_frameDone <= 1'b1;
              r_cmdQ      <= r_rxSr;
            end else begin
              r_frameErr <= 1'b1;
            end
          end else if (w_sclkRise) begin
            r_rxSr <= {r_rxSr[14:0], r_mosiSync};
            if (r_bitCnt != BIT_CNT_MAX) r_bitCnt <= r_bitCnt + 1'b1;
          end else if (w_sclkFall) begin
            r_txSr <= {r_txSr[14:0], 1'b0};
          end
        end
        default: r_state <= ST_DISARMED;
      endcase
    end
  end

  always_comb begin
    w_resp     = RESP_ZERO;
    w_wrCmd    = 1'b0;
    w_convInc  = 1'b0;
    w_convClr  = 1'b0;
    w_calStart = 1'b0;
    if (r_calLeft != '0) begin
      w_resp = RESP_ZERO;
    end else if (r_rxSr == CMD_CALIBRATE) begin
      w_calStart = 1'b1;
    end else if (r_rxSr == CMD_CLEAR) begin
      w_convClr = 1'b1;
    end else begin
      case (r_rxSr[15:14])
        CMD_CONVERT: begin
          w_resp    = {r_rxSr[13:8], 10'(r_convCnt)};
          w_convInc = 1'b1;
        end
        CMD_WRITE: begin
          w_resp  = {RET_WRITE, r_rxSr[7:0]};
          w_wrCmd = 1'b1;
        end
        CMD_READ:    w_resp = {RET_READ, w_rdData};
        CMD_ILLEGAL: w_resp = RESP_ILLEGAL;
        default:     w_resp = RESP_ILLEGAL;
      endcase
    end
  end

  spi_adc_regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .i_wrEn   (w_exec & w_wrCmd),
    .i_addr   (r_rxSr[13:8]),
    .i_wrData (r_rxSr[7:0]),
    .o_rdData (w_rdData),
    .o_reg3Q  (o_reg3Q)
  );

`ifdef SPI_RESP_LATENCY2_EN
  logic [15:0] r_pipe1;
  assign w_respOut = r_pipe1;
`else
  assign w_respOut = r_pipe0;
`endif

  // Conversion counter, calibration skip counter and response pipeline only move on a good frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_convCnt <= '0;
      r_calLeft <= '0;
      r_pipe0   <= RESP_ZERO;
`ifdef SPI_RESP_LATENCY2_EN
      r_pipe1   <= RESP_ZERO;
`endif
    end else if (w_exec) begin
      r_pipe0 <= w_resp;
`ifdef SPI_RESP_LATENCY2_EN
      r_pipe1 <= r_pipe0;
`endif
      if (r_calLeft != '0)  r_calLeft <= r_calLeft - 1'b1;
      else if (w_calStart)  r_calLeft <= CAL_W'(CAL_FRAMES);
      if (w_convClr)        r_convCnt <= '0;
      else if (w_convInc)   r_convCnt <= r_convCnt + 1'b1;
    end
  end

  assign o_miso      = ~r_csSync & r_txSr[15];
  assign o_frameDone = r_frameDone;
  assign o_frameErr  = r_frameErr;
  assign o_cmdQ      = r_cmdQ;

endmodule

// File: tb/tb_spi_adc_responder.sv
// Scoreboard bench for spi_adc_responder: the driver queues hand-computed responses, a monitor checks each frame pulse.
module tb_spi_adc_responder;

`ifdef SPI_RESP_LATENCY2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst, sclk, cs, mosi;
  logic        o_miso, o_frameDone, o_frameErr;
  logic [7:0]  o_reg3Q;
  logic [15:0] o_cmdQ;

  int checks = 0;
  int failures = 0;
  int pulseCount = 0;

  typedef struct {
    logic        isErr;
    logic        chkMiso;
    logic [15:0] miso;
    logic [15:0] cmdQ;
    logic [7:0]  reg3;
  } expEntry_t;

  expEntry_t   expQ[$];
  logic [15:0] capQ[$];
  logic [15:0] pipeQ[$];
  logic [15:0] lastCmd;
  logic [7:0]  expReg3;

  always #5 clk = ~clk;

  spi_adc_responder dut (
    .clk         (clk),
    .rst         (rst),
    .i_sclk      (sclk),
    .i_cs        (cs),
    .i_mosi      (mosi),
    .o_miso      (o_miso),
    .o_reg3Q     (o_reg3Q),
    .o_frameDone (o_frameDone),
    .o_frameErr  (o_frameErr),
    .o_cmdQ      (o_cmdQ)
  );

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_miso"},       16'(o_miso),      16'h0000);
    checkOutput({tag, "_reg3_q"},     16'(o_reg3Q),     16'h0000);
    checkOutput({tag, "_frame_done"}, 16'(o_frameDone), 16'h0000);
    checkOutput({tag, "_frame_err"},  16'(o_frameErr),  16'h0000);
    checkOutput({tag, "_cmd_q"},      o_cmdQ,           16'h0000);
  endtask

  task automatic resetModel();
    pipeQ.delete();
    for (int i = 0; i < LAT; i++) pipeQ.push_back(16'h0000);
    lastCmd = 16'h0000;
    expReg3 = 8'h00;
  endtask

  // One sclk period: miso is sampled at the end of the high phase.
  task automatic clockBit(input logic b, output logic m);
    mosi = b;
    repeat (2) @(negedge clk);
    sclk = 1'b1;
    repeat (2) @(negedge clk);
    m = o_miso;
    sclk = 1'b0;
  endtask

  task automatic applyStimulus(input logic [15:0] cmd, input logic [15:0] expResp, input int nbits = 16);
    expEntry_t   e;
    logic [15:0] word;
    logic        m;
    e.isErr   = (nbits != 16);
    e.chkMiso = !e.isErr;
    e.miso    = 16'h0000;
    if (!e.isErr) begin
      e.miso = pipeQ.pop_front();
      pipeQ.push_back(expResp);
      lastCmd = cmd;
    end
    e.cmdQ = lastCmd;
    e.reg3 = expReg3;
    expQ.push_back(e);
    word = 16'h0000;
    @(negedge clk);
    cs = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      clockBit((i < 16) ? cmd[15 - i] : 1'b0, m);
      word = {word[14:0], m};
    end
    repeat (3) @(negedge clk);
    capQ.push_back(word);
    cs = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin : monitor
    expEntry_t   e;
    logic [15:0] w;
    forever begin
      @(negedge clk);
      if (o_frameDone || o_frameErr) begin
        pulseCount++;
        if (expQ.size() == 0 || capQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_pulse done=%b err=%b expected no pulse at %0t", o_frameDone, o_frameErr, $time);
        end else begin
          e = expQ.pop_front();
          w = capQ.pop_front();
          checkOutput("pulse_is_err", 16'(o_frameErr),  16'(e.isErr));
          checkOutput("pulse_is_done", 16'(o_frameDone), 16'(!e.isErr));
          checkOutput("cmd_q", o_cmdQ, e.cmdQ);
          checkOutput("reg3_q", 16'(o_reg3Q), 16'(e.reg3));
          if (e.chkMiso) checkOutput("miso_word", w, e.miso);
        end
      end
    end
  end

  initial begin : driver
    logic [15:0] abortCmd;
    logic        m;
    int          pulsesBefore;
    rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    resetModel();
    repeat (4) @(negedge clk);
    checkResetValues("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    expReg3 = 8'h01;
    applyStimulus(16'h8301, 16'hFF01);
    applyStimulus(16'hC300, 16'h0001);
    applyStimulus(16'h0000, 16'h0000);
    applyStimulus(16'h0000, 16'h0001);

    applyStimulus(16'hE800, 16'h0049);
    for (int i = 0; i < 4; i++) applyStimulus(16'hC300, 16'h0001);
    applyStimulus(16'hEC00, 16'h004E);
    applyStimulus(16'hD400, 16'h0000);
    applyStimulus(16'hFF00, 16'h0001);
    applyStimulus(16'h9177, 16'hFF77);
    applyStimulus(16'hD100, 16'h0077);
    applyStimulus(16'h92AA, 16'hFFAA);
    applyStimulus(16'hD200, 16'h0000);

    applyStimulus(16'h4123, 16'hFFFF);
    applyStimulus(16'h5501, 16'hFFFF);
    applyStimulus(16'hC300, 16'h0001);

    applyStimulus(16'h5500, 16'h0000);
    for (int i = 0; i < 9; i++) applyStimulus(16'h8355, 16'h0000);
    expReg3 = 8'h55;
    applyStimulus(16'h8355, 16'hFF55);
    applyStimulus(16'hC300, 16'h0055);

    applyStimulus(16'h83AA, 16'h0000, 15);
    applyStimulus(16'h83AA, 16'h0000, 17);
    applyStimulus(16'hC300, 16'h0055);

    applyStimulus(16'h6A00, 16'h0000);
    for (int i = 0; i <= 1024; i++) applyStimulus(16'h0500, 16'h1400 | 16'(i % 1024));
    applyStimulus(16'h6A00, 16'h0000);
    applyStimulus(16'h0500, 16'h1400);
    applyStimulus(16'h3F00, 16'hFC01);

    abortCmd = 16'h83CC;
    repeat (20) @(negedge clk);
    pulsesBefore = pulseCount;
    cs = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++) clockBit(abortCmd[15 - i], m);
    rst = 1'b1;
    @(negedge clk);
    checkResetValues("midreset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 6; i < 16; i++) clockBit(abortCmd[15 - i], m);
    repeat (3) @(negedge clk);
    cs = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("abort_no_pulse", 16'(pulseCount - pulsesBefore), 16'h0000);
    resetModel();

    applyStimulus(16'hC300, 16'h0000);
    expReg3 = 8'h77;
    applyStimulus(16'h8377, 16'hFF77);
    applyStimulus(16'h0000, 16'h0000);
    applyStimulus(16'h0000, 16'h0001);
    for (int i = 0; i < LAT; i++) applyStimulus(16'hC300, 16'h0077);

    repeat (20) @(negedge clk);
    checkOutput("scoreboard_drained", 16'(expQ.size()), 16'h0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
